// File: rtl/armleocpu_csr_sequencer.sv
// CSR command-port front end: arbitrates trap writes against execute-stage
// accesses and expands READ_SET/READ_CLEAR into a read followed by a write.
module armleocpu_csr_sequencer #(
  parameter int CMD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exec_req_valid,
  output logic                 exec_req_ready,
  input  logic [2:0]           exec_req_op,
  input  logic [11:0]          exec_req_addr,
  input  logic [31:0]          exec_req_wdata,
  output logic                 exec_rsp_valid,
  input  logic                 exec_rsp_ready,
  output logic [31:0]          exec_rsp_rdata,
  output logic                 exec_rsp_invalid,
  input  logic                 trap_req_valid,
  output logic                 trap_req_ready,
  input  logic [11:0]          trap_req_addr,
  input  logic [31:0]          trap_req_wdata,
  output logic                 trap_done,
  output logic                 busy,
  output logic [CMD_WIDTH-1:0] csr_cmd,
  output logic [11:0]          csr_address,
  output logic [31:0]          csr_writedata,
  input  logic [31:0]          csr_readdata,
  input  logic                 csr_invalid
);

  localparam logic [CMD_WIDTH-1:0] CMD_NONE       = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] CMD_READ       = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CMD_WRITE      = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] CMD_READ_WRITE = CMD_WIDTH'(3);

  localparam logic [2:0] OP_WRITE      = 3'd1;
  localparam logic [2:0] OP_READ_WRITE = 3'd2;
  localparam logic [2:0] OP_READ_SET   = 3'd3;
  localparam logic [2:0] OP_READ_CLEAR = 3'd4;

  typedef enum logic [2:0] {IDLE, TRAP_WR, EXEC_ACC, EXEC_WR, RESP} state_t;

  state_t               state;
  logic [2:0]           op_q;
  logic [31:0]          mask_q;
  logic [CMD_WIDTH-1:0] acc_cmd;
  logic [31:0]          acc_wdata;
  logic                 rmw_op;
  logic [31:0]          rmw_value;

  assign trap_req_ready = (state == IDLE) & trap_req_valid;
  assign exec_req_ready = (state == IDLE) & exec_req_valid & ~trap_req_valid;

  always_comb begin
    acc_cmd   = CMD_READ;
    acc_wdata = '0;
    case (exec_req_op)
      OP_WRITE:      begin acc_cmd = CMD_WRITE;      acc_wdata = exec_req_wdata; end
      OP_READ_WRITE: begin acc_cmd = CMD_READ_WRITE; acc_wdata = exec_req_wdata; end
      default:       ;
    endcase
  end

  assign rmw_op    = (op_q == OP_READ_SET) | (op_q == OP_READ_CLEAR);
  // csr_readdata is sampled in EXEC_ACC, so the write value is the captured read data
  assign rmw_value = (op_q == OP_READ_SET) ? (csr_readdata | mask_q)
                                           : (csr_readdata & ~mask_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      op_q             <= '0;
      mask_q           <= '0;
      exec_rsp_valid   <= 1'b0;
      exec_rsp_rdata   <= '0;
      exec_rsp_invalid <= 1'b0;
      trap_done        <= 1'b0;
      busy             <= 1'b0;
      csr_cmd          <= CMD_NONE;
      csr_address      <= '0;
      csr_writedata    <= '0;
    end else begin
      trap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trap_req_valid) begin
            state         <= TRAP_WR;
            busy          <= 1'b1;
            csr_cmd       <= CMD_WRITE;
            csr_address   <= trap_req_addr;
            csr_writedata <= trap_req_wdata;
          end else if (exec_req_valid) begin
            busy <= 1'b1;
            if (exec_req_op <= OP_READ_CLEAR) begin
              state         <= EXEC_ACC;
              op_q          <= exec_req_op;
              mask_q        <= exec_req_wdata;
              csr_cmd       <= acc_cmd;
              csr_address   <= exec_req_addr;
              csr_writedata <= acc_wdata;
            end else begin
              state            <= RESP;
              exec_rsp_valid   <= 1'b1;
              exec_rsp_rdata   <= '0;
              exec_rsp_invalid <= 1'b1;
            end
          end
        end
        TRAP_WR: begin
          state         <= IDLE;
          busy          <= 1'b0;
          trap_done     <= 1'b1;
          csr_cmd       <= CMD_NONE;
          csr_address   <= '0;
          csr_writedata <= '0;
        end
        EXEC_ACC: begin
          exec_rsp_rdata   <= csr_readdata;
          exec_rsp_invalid <= csr_invalid;
          if (rmw_op && !csr_invalid && (mask_q != '0)) begin
            state         <= EXEC_WR;
            csr_cmd       <= CMD_WRITE;
            csr_writedata <= rmw_value;
          end else begin
            state          <= RESP;
            exec_rsp_valid <= 1'b1;
            csr_cmd        <= CMD_NONE;
            csr_address    <= '0;
            csr_writedata  <= '0;
          end
        end
        EXEC_WR: begin
          state            <= RESP;
          exec_rsp_valid   <= 1'b1;
          exec_rsp_invalid <= exec_rsp_invalid | csr_invalid;
          csr_cmd          <= CMD_NONE;
          csr_address      <= '0;
          csr_writedata    <= '0;
        end
        RESP: begin
          if (exec_rsp_ready) begin
            state          <= IDLE;
            busy           <= 1'b0;
            exec_rsp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_csr_sequencer.sv
// Directed bench for armleocpu_csr_sequencer with a small behavioural CSR unit
// (mscratch, mepc read-write; mvendorid read-only; everything else invalid).
module tb_armleocpu_csr_sequencer;

  localparam logic [3:0] C_NONE = 4'd0;
  localparam logic [3:0] C_READ = 4'd1;
  localparam logic [3:0] C_WR   = 4'd2;
  localparam logic [3:0] C_RW   = 4'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exec_req_valid = 1'b0;
  logic        exec_req_ready;
  logic [2:0]  exec_req_op = '0;
  logic [11:0] exec_req_addr = '0;
  logic [31:0] exec_req_wdata = '0;
  logic        exec_rsp_valid;
  logic        exec_rsp_ready = 1'b0;
  logic [31:0] exec_rsp_rdata;
  logic        exec_rsp_invalid;
  logic        trap_req_valid = 1'b0;
  logic        trap_req_ready;
  logic [11:0] trap_req_addr = '0;
  logic [31:0] trap_req_wdata = '0;
  logic        trap_done;
  logic        busy;
  logic [3:0]  csr_cmd;
  logic [11:0] csr_address;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic        csr_invalid;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  armleocpu_csr_sequencer #(.CMD_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .exec_req_valid(exec_req_valid), .exec_req_ready(exec_req_ready),
    .exec_req_op(exec_req_op), .exec_req_addr(exec_req_addr),
    .exec_req_wdata(exec_req_wdata),
    .exec_rsp_valid(exec_rsp_valid), .exec_rsp_ready(exec_rsp_ready),
    .exec_rsp_rdata(exec_rsp_rdata), .exec_rsp_invalid(exec_rsp_invalid),
    .trap_req_valid(trap_req_valid), .trap_req_ready(trap_req_ready),
    .trap_req_addr(trap_req_addr), .trap_req_wdata(trap_req_wdata),
    .trap_done(trap_done), .busy(busy),
    .csr_cmd(csr_cmd), .csr_address(csr_address), .csr_writedata(csr_writedata),
    .csr_readdata(csr_readdata), .csr_invalid(csr_invalid)
  );

  // Behavioural CSR unit: combinational read/invalid, write on the clock edge.
  logic [31:0] mscratch = '0;
  logic [31:0] mepc = '0;
  logic        known;
  logic        ro;

  always_comb begin
    known        = 1'b1;
    ro           = 1'b0;
    csr_readdata = '0;
    case (csr_address)
      12'h340: csr_readdata = mscratch;
      12'h341: csr_readdata = mepc;
      12'hF11: begin csr_readdata = 32'h0A1AA1E0; ro = 1'b1; end
      default: known = 1'b0;
    endcase
    csr_invalid = (csr_cmd != C_NONE) &&
                  (!known || (ro && (csr_cmd == C_WR || csr_cmd == C_RW)));
  end

  always @(posedge clk) begin
    if ((csr_cmd == C_WR || csr_cmd == C_RW) && !csr_invalid) begin
      if (csr_address == 12'h340) mscratch <= csr_writedata;
      if (csr_address == 12'h341) mepc <= csr_writedata;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic issue_exec(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    exec_req_valid = 1'b1;
    exec_req_op    = op;
    exec_req_addr  = addr;
    exec_req_wdata = wd;
    #1;
    while (!exec_req_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("exec_req_ready", 32'(exec_req_ready), 32'd1);
    @(posedge clk);
    #1 exec_req_valid = 1'b0;
  endtask

  // Counts cycles from accept to rsp_valid and records WRITE-type commands on the way.
  task automatic wait_rsp(input string tag, input logic [31:0] exp_rd, input logic exp_inv,
                          input int exp_lat, input int exp_nwr, input logic [31:0] exp_wd);
    int lat = 0;
    int nwr = 0;
    logic [31:0] lastw = '0;
    do begin
      @(negedge clk);
      lat++;
      if (!exec_rsp_valid && (csr_cmd == C_WR || csr_cmd == C_RW)) begin
        nwr++;
        lastw = csr_writedata;
      end
    end while (!exec_rsp_valid && lat < 10);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, exec_rsp_rdata, exp_rd);
    check({tag, " invalid"}, 32'(exec_rsp_invalid), 32'(exp_inv));
    check({tag, " write_cycles"}, 32'(nwr), 32'(exp_nwr));
    if (exp_nwr > 0) check({tag, " write_data"}, lastw, exp_wd);
    exec_rsp_ready = 1'b1;
    @(posedge clk);
    #1 exec_rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_inv;
    int          exp_lat;
    int          exp_nwr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{3'd0, 12'h340, 32'h0,          32'h0,          1'b0, 2, 0, 32'h0};
    vecs[1]  = '{3'd1, 12'h340, 32'hA5A5_0000,  32'h0,          1'b0, 2, 1, 32'hA5A5_0000};
    vecs[2]  = '{3'd3, 12'h340, 32'h0000_00FF,  32'hA5A5_0000,  1'b0, 3, 1, 32'hA5A5_00FF};
    vecs[3]  = '{3'd0, 12'h340, 32'h0,          32'hA5A5_00FF,  1'b0, 2, 0, 32'h0};
    vecs[4]  = '{3'd4, 12'h340, 32'h0,          32'hA5A5_00FF,  1'b0, 2, 0, 32'h0};
    vecs[5]  = '{3'd4, 12'h340, 32'h0000_000F,  32'hA5A5_00FF,  1'b0, 3, 1, 32'hA5A5_00F0};
    vecs[6]  = '{3'd2, 12'h340, 32'h1234_5678,  32'hA5A5_00F0,  1'b0, 2, 1, 32'h1234_5678};
    vecs[7]  = '{3'd3, 12'hF11, 32'h0000_0001,  32'h0A1A_A1E0,  1'b1, 3, 1, 32'h0A1A_A1E1};
    vecs[8]  = '{3'd0, 12'h7FF, 32'h0,          32'h0,          1'b1, 2, 0, 32'h0};
    vecs[9]  = '{3'd3, 12'h7FF, 32'h0000_0001,  32'h0,          1'b1, 2, 0, 32'h0};
    vecs[10] = '{3'd6, 12'h340, 32'hFFFF_FFFF,  32'h0,          1'b1, 1, 0, 32'h0};
    vecs[11] = '{3'd5, 12'h340, 32'h0,          32'h0,          1'b1, 1, 0, 32'h0};
    vecs[12] = '{3'd7, 12'h340, 32'h0,          32'h0,          1'b1, 1, 0, 32'h0};
    vecs[13] = '{3'd0, 12'h340, 32'h0,          32'h1234_5678,  1'b0, 2, 0, 32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rsp_valid", 32'(exec_rsp_valid), 32'd0);
    check("reset csr_cmd", 32'(csr_cmd), 32'(C_NONE));
    check("reset csr_address", 32'(csr_address), 32'd0);
    check("reset trap_done", 32'(trap_done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue_exec(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      wait_rsp($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_inv,
               vecs[i].exp_lat, vecs[i].exp_nwr, vecs[i].exp_wd);
    end

    // Simultaneous trap and exec: trap wins, exec follows in the next IDLE cycle
    @(negedge clk);
    trap_req_valid = 1'b1; trap_req_addr = 12'h341; trap_req_wdata = 32'hDEAD_BEEF;
    exec_req_valid = 1'b1; exec_req_op = 3'd0; exec_req_addr = 12'h341; exec_req_wdata = '0;
    #1;
    check("arb trap_ready", 32'(trap_req_ready), 32'd1);
    check("arb exec_ready", 32'(exec_req_ready), 32'd0);
    @(posedge clk);
    #1 trap_req_valid = 1'b0;
    @(negedge clk);
    check("trap csr_cmd", 32'(csr_cmd), 32'(C_WR));
    check("trap csr_address", 32'(csr_address), 32'h341);
    check("trap csr_writedata", csr_writedata, 32'hDEAD_BEEF);
    check("trap busy", 32'(busy), 32'd1);
    check("trap exec_ready", 32'(exec_req_ready), 32'd0);
    check("trap_done early", 32'(trap_done), 32'd0);
    @(negedge clk);
    check("trap_done pulse", 32'(trap_done), 32'd1);
    check("post-trap exec_ready", 32'(exec_req_ready), 32'd1);
    check("post-trap busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 exec_req_valid = 1'b0;
    wait_rsp("after_trap", 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0);

    // Illegal op with a held response; a pending trap must wait
    issue_exec(3'd6, 12'h340, 32'h0);
    @(negedge clk);
    check("illegal rsp_valid", 32'(exec_rsp_valid), 32'd1);
    check("illegal invalid", 32'(exec_rsp_invalid), 32'd1);
    check("illegal csr_cmd", 32'(csr_cmd), 32'(C_NONE));
    trap_req_valid = 1'b1; trap_req_addr = 12'h341; trap_req_wdata = 32'h1111_2222;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d rsp_valid", k), 32'(exec_rsp_valid), 32'd1);
      check($sformatf("hold%0d rdata", k), exec_rsp_rdata, 32'h0);
      check($sformatf("hold%0d invalid", k), 32'(exec_rsp_invalid), 32'd1);
      check($sformatf("hold%0d trap_ready", k), 32'(trap_req_ready), 32'd0);
      check($sformatf("hold%0d csr_cmd", k), 32'(csr_cmd), 32'(C_NONE));
    end
    exec_rsp_ready = 1'b1;
    @(posedge clk);
    #1 exec_rsp_ready = 1'b0;
    check("idle trap_ready", 32'(trap_req_ready), 32'd1);
    check("idle rsp_valid", 32'(exec_rsp_valid), 32'd0);
    @(posedge clk);
    #1 trap_req_valid = 1'b0;
    @(negedge clk);
    check("trap2 csr_cmd", 32'(csr_cmd), 32'(C_WR));
    @(negedge clk);
    check("trap2 done", 32'(trap_done), 32'd1);
    @(negedge clk);
    check("trap2 done single", 32'(trap_done), 32'd0);
    issue_exec(3'd0, 12'h341, 32'h0);
    wait_rsp("read_mepc", 32'h1111_2222, 1'b0, 2, 0, 32'h0);

    // Asynchronous reset while the RMW write phase is on the CSR port
    issue_exec(3'd3, 12'h340, 32'h0000_0100);
    @(negedge clk);
    check("rst acc csr_cmd", 32'(csr_cmd), 32'(C_READ));
    @(posedge clk);
    #2;
    check("rst wr csr_cmd", 32'(csr_cmd), 32'(C_WR));
    #1 rst_n = 1'b0;
    #1;
    check("async csr_cmd", 32'(csr_cmd), 32'(C_NONE));
    check("async csr_address", 32'(csr_address), 32'd0);
    check("async csr_writedata", csr_writedata, 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async rsp_valid", 32'(exec_rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst busy", 32'(busy), 32'd0);
    check("post-rst csr_cmd", 32'(csr_cmd), 32'(C_NONE));
    issue_exec(3'd0, 12'h340, 32'h0);
    wait_rsp("post_rst_read", 32'h1234_5678, 1'b0, 2, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/armleocpu_csr_sequencer.md
Name: armleocpu_csr_sequencer

Overview:
- Front-end controller for the CSR register unit. Owns its single command port (csr_cmd / csr_address / csr_writedata, with csr_readdata / csr_invalid back).
- Arbitrates between the execute stage (CSR instructions) and the trap logic (trap-entry CSR writes).
- Expands READ_SET / READ_CLEAR into a two-phase read-modify-write, because the CSR unit only decodes READ, WRITE and READ_WRITE as accesses.
- Returns read data and the invalid flag to the execute stage over a valid/ready response channel.

Parameters:
CMD_WIDTH, 4, width of csr_cmd; must match the codebase CSR command width macro.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- exec_req_valid  in  1  execute stage requests a CSR access.
- exec_req_ready  out  1  request accepted this cycle.
- exec_req_op  in  3  0 READ, 1 WRITE, 2 READ_WRITE, 3 READ_SET, 4 READ_CLEAR, 5-7 illegal.
- exec_req_addr  in  12  CSR address.
- exec_req_wdata  in  32  write data, or set/clear mask.
- exec_rsp_valid  out  1  response available.
- exec_rsp_ready  in  1  execute stage consumes the response.
- exec_rsp_rdata  out  32  old CSR value.
- exec_rsp_invalid  out  1  access faulted; execute stage raises illegal instruction.
- trap_req_valid  in  1  trap logic requests a CSR write (e.g. MEPC or MCAUSE).
- trap_req_ready  out  1  trap request accepted this cycle.
- trap_req_addr  in  12  CSR address.
- trap_req_wdata  in  32  write data.
- trap_done  out  1  one-cycle pulse when the trap write has completed.
- busy  out  1  state is not IDLE.
- csr_cmd  out  CMD_WIDTH  command to the CSR unit (NONE/READ/WRITE/READ_WRITE).
- csr_address  out  12  address to the CSR unit.
- csr_writedata  out  32  write data to the CSR unit.
- csr_readdata  in  32  combinational read data from the CSR unit.
- csr_invalid  in  1  combinational invalid flag from the CSR unit.

Behaviour:
- Reset (async, rst_n low):
  - State returns to IDLE.
  - All captured registers are cleared.
  - exec_rsp_valid=0, exec_rsp_rdata=0, exec_rsp_invalid=0, trap_done=0, busy=0.
  - csr_cmd=NONE, csr_address=0, csr_writedata=0.
  - A pending response or in-flight RMW is dropped; a write already clocked into the CSR unit is not undone.
- csr_cmd is NONE in every state except TRAP_WR, EXEC_ACC and EXEC_WR.
- csr_address and csr_writedata are 0 when csr_cmd is NONE.
- State IDLE:
  - trap_req_ready=1 whenever trap_req_valid=1.
  - exec_req_ready = exec_req_valid & ~trap_req_valid. Trap has strict priority; when both are valid, trap is accepted and exec waits.
  - On trap accept: capture addr/wdata, go to TRAP_WR.
  - On exec accept with op<=4: capture op/addr/wdata, go to EXEC_ACC.
  - On exec accept with op>=5: set rsp_rdata=0, rsp_invalid=1, go to RESP. No CSR access occurs.
- State TRAP_WR (1 cycle):
  - csr_cmd=WRITE with the captured addr/data; go to IDLE.
  - trap_done=1 in the following cycle (registered pulse).
  - csr_invalid is ignored; trap writes are trusted.
- State EXEC_ACC (1 cycle):
  - csr_cmd = READ for READ/SET/CLEAR, WRITE for WRITE, READ_WRITE for READ_WRITE.
  - Capture rsp_rdata=csr_readdata and rsp_invalid=csr_invalid.
  - Go to EXEC_WR if op is SET or CLEAR, csr_invalid=0 and mask!=0. Otherwise go to RESP. A zero mask never writes.
  - Set value = rdata | mask; clear value = rdata & ~mask, computed from the captured read data.
- State EXEC_WR (1 cycle):
  - csr_cmd=WRITE with the computed value.
  - rsp_invalid |= csr_invalid (catches read-only CSRs); go to RESP.
- State RESP:
  - exec_rsp_valid=1; rdata/invalid stay stable.
  - On exec_rsp_ready go to IDLE. A new request is accepted no earlier than the next cycle.
  - trap_req_ready=0.
- No preemption: a trap arriving in EXEC_* or RESP waits until IDLE.
- Latency from accept to rsp_valid: 2 cycles for READ/WRITE/READ_WRITE (or a zero mask), 3 cycles for SET/CLEAR, 1 cycle for an illegal op.
- busy=1 in every state except IDLE.

Test Plan:
- Reset, then exec READ 0x340 (mscratch=0) → csr_cmd=READ one cycle, rsp_valid 2 cycles after accept, rdata=0, invalid=0.
- Exec WRITE 0x340 data 0xA5A5_0000, then READ_SET 0x340 mask 0x0000_00FF → second op shows READ then WRITE 0xA5A5_00FF; rsp_rdata=0xA5A5_0000; a subsequent READ returns 0xA5A5_00FF.
- READ_CLEAR 0x340 mask 0 → only the READ cycle occurs, no WRITE cycle; rsp 2 cycles after accept. READ_SET 0xF11 mask 1 → READ then WRITE cycle; CSR unit flags invalid; rsp_invalid=1, rdata=0x0A1AA1E0.
- trap_req_valid and exec_req_valid asserted in the same cycle → trap_req_ready=1, exec_req_ready=0; WRITE to trap addr; trap_done pulse; exec accepted in the following IDLE cycle.
- Exec op=6 → rsp_valid next cycle, invalid=1, csr_cmd stays NONE. Hold exec_rsp_ready=0 for 5 cycles → rsp stable, trap_req_ready=0 throughout.
- Assert rst_n=0 asynchronously during EXEC_WR → outputs clear immediately without a clock edge; after release, busy=0 and csr_cmd=NONE.
